serial_mmio: RTL and testbench



---
 rtl/serial_mmio.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_serial_mmio.sv | 551 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mmio.sv
// serial_mmio: MMIO-mapped serial peripheral with TX/RX FIFOs.
// Characters are pulse-width coded: every bit slot starts high and ends low,
// and the length of the high part carries the bit value. The receive side is
// synchronised, measures the high width and rebuilds characters MSB first.
module serial_mmio #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          BIT_PERIOD = 16,
    parameter logic [3:0]  PAGE       = 4'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [15:0] mmio_rdata,
    output logic        serial_tx,
    input  logic        serial_rx,
    output logic        irq
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SCW = $clog2(BIT_PERIOD);
    localparam int HCW = $clog2(BIT_PERIOD + 1);
    localparam int LCW = $clog2(2 * BIT_PERIOD + 2);

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel_s;
    logic [3:0] off_s;
    logic       wr_s;
    logic       rd_s;
    logic       ctrl_wr_s;
    logic       unused_s;

    assign sel_s     = mmio_addr[15] & (mmio_addr[11:8] == PAGE);
    assign off_s     = mmio_addr[3:0];
    assign wr_s      = sel_s & mmio_we;
    assign rd_s      = sel_s & mmio_re;
    assign ctrl_wr_s = wr_s & (off_s == 4'd3);
    assign unused_s  = ^{mmio_addr[14:12], mmio_addr[7:4], mmio_wdata};

    // ------------------------------------------------------------------
    // Control and sticky flags
    // ------------------------------------------------------------------
    logic [3:0] ctrl_q, ctrl_d;
    logic       rx_ovf_q, rx_ovf_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       clr_sticky_s;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic              tx_full_s, tx_empty_s;
    logic              tx_push_req_s, tx_push_s, tx_pop_s;
    logic [DATA_W-1:0] tx_head_s;

    assign tx_full_s     = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign tx_empty_s    = (tx_cnt_q == {CW{1'b0}});
    assign tx_push_req_s = wr_s & (off_s == 4'd2);
    // A full FIFO refuses the write even if the FSM pops in the same cycle.
    assign tx_push_s     = tx_push_req_s & ~tx_full_s;
    assign tx_head_s     = tx_mem_q[tx_rd_q];
    assign tx_wr_d       = tx_push_s ? (tx_wr_q + AW'(1)) : tx_wr_q;
    assign tx_rd_d       = tx_pop_s  ? (tx_rd_q + AW'(1)) : tx_rd_q;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic              rx_full_s, rx_empty_s;
    logic              rx_push_req_s, rx_push_s, rx_pop_s, rx_ovf_set_s;
    logic [DATA_W-1:0] rx_push_data_s;
    logic [DATA_W-1:0] rx_head_s;

    assign rx_full_s    = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty_s   = (rx_cnt_q == {CW{1'b0}});
    assign rx_pop_s     = rd_s & (off_s == 4'd1) & ~rx_empty_s;
    // A same-cycle pop frees the slot, so a push into a full FIFO survives.
    assign rx_push_s    = rx_push_req_s & (~rx_full_s | rx_pop_s);
    assign rx_ovf_set_s = rx_push_req_s & rx_full_s & ~rx_pop_s;
    assign rx_head_s    = rx_mem_q[rx_rd_q];
    assign rx_wr_d      = rx_push_s ? (rx_wr_q + AW'(1)) : rx_wr_q;
    assign rx_rd_d      = rx_pop_s  ? (rx_rd_q + AW'(1)) : rx_rd_q;

    // Next FIFO occupancy from push/pop pairs; counts saturate by construction.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
        rx_cnt_d = rx_cnt_q;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // FIFO storage arrays; contents need no reset because counts gate them.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_q] <= mmio_wdata[DATA_W-1:0];
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wr_q] <= rx_push_data_s;
        end
    end

    // Control register and sticky overflow flags; a new overflow beats a clear.
    always_comb begin
        clr_sticky_s = ctrl_wr_s & mmio_wdata[4];
        ctrl_d       = ctrl_wr_s ? mmio_wdata[3:0] : ctrl_q;
        rx_ovf_d     = rx_ovf_set_s | (rx_ovf_q & ~clr_sticky_s);
        tx_ovf_d     = (tx_push_req_s & tx_full_s) | (tx_ovf_q & ~clr_sticky_s);
    end

    // ------------------------------------------------------------------
    // TX state machine and line encoder
    // ------------------------------------------------------------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [BCW-1:0]    tx_bit_q, tx_bit_d;
    logic [SCW-1:0]    tx_slot_q, tx_slot_d;
    logic              serial_tx_q, serial_tx_d;
    logic              tx_busy_s;

    assign tx_busy_s = (tx_state_q == TX_SEND);

    // TX next state: load from FIFO in IDLE, walk slots and bits in SEND.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_slot_d  = tx_slot_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (ctrl_q[0] && !tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_d = tx_head_s;
                    tx_bit_d   = BCW'(DATA_W - 1);
                    tx_slot_d  = {SCW{1'b0}};
                    tx_state_d = TX_SEND;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (tx_slot_q == SCW'(BIT_PERIOD - 1)) begin
                    tx_slot_d = {SCW{1'b0}};
                    if (tx_bit_q == {BCW{1'b0}}) begin
                        // Chain the next character with no idle slot between.
                        if (ctrl_q[0] && !tx_empty_s) begin
                            tx_pop_s   = 1'b1;
                            tx_shift_d = tx_head_s;
                            tx_bit_d   = BCW'(DATA_W - 1);
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q - BCW'(1);
                        tx_shift_d = tx_shift_q << 1;
                    end
                end else begin
                    tx_slot_d = tx_slot_q + SCW'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // Line encoder: high quarter, data half, low quarter of every slot.
    always_comb begin
        serial_tx_d = 1'b0;
        if (tx_state_q == TX_SEND) begin
            if (tx_slot_q < SCW'(BIT_PERIOD / 4)) begin
                serial_tx_d = 1'b1;
            end else if (tx_slot_q < SCW'((3 * BIT_PERIOD) / 4)) begin
                serial_tx_d = tx_shift_q[DATA_W-1];
            end else begin
                serial_tx_d = 1'b0;
            end
        end else begin
            serial_tx_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser, pulse measurement and character assembly
    // ------------------------------------------------------------------
    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    logic [HCW-1:0]    hi_cnt_q, hi_cnt_d;
    logic [LCW-1:0]    lo_cnt_q, lo_cnt_d;
    logic              pulse_q, pulse_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [BCW-1:0]    rx_bits_q, rx_bits_d;
    logic              rise_s, fall_s, rx_bit_s, bit_valid_s, gap_s;
    logic [DATA_W-1:0] rx_bit_ext_s, rx_shift_next_s;

    assign rise_s = rx_s2_q & ~rx_s3_q;
    assign fall_s = ~rx_s2_q & rx_s3_q;

    // RX decode: classify each completed pulse and assemble characters.
    always_comb begin
        rx_bit_s        = (hi_cnt_q >= HCW'(BIT_PERIOD / 2));
        // Only pulses whose rising edge was seen while enabled, and at least
        // two cycles long, count as bits.
        bit_valid_s     = ctrl_q[1] & fall_s & pulse_q & (hi_cnt_q >= HCW'(2));
        gap_s           = (lo_cnt_q > LCW'(2 * BIT_PERIOD));
        rx_bit_ext_s    = {DATA_W{1'b0}};
        rx_bit_ext_s[0] = rx_bit_s;
        rx_shift_next_s = (rx_shift_q << 1) | rx_bit_ext_s;
        rx_push_req_s   = bit_valid_s & (rx_bits_q == BCW'(DATA_W - 1));
        rx_push_data_s  = rx_shift_next_s;

        hi_cnt_d = rx_s2_q ? ((hi_cnt_q == HCW'(BIT_PERIOD)) ? hi_cnt_q : hi_cnt_q + HCW'(1))
                           : {HCW{1'b0}};
        lo_cnt_d = rx_s2_q ? {LCW{1'b0}}
                           : (gap_s ? lo_cnt_q : lo_cnt_q + LCW'(1));

        pulse_d = pulse_q;
        if (!ctrl_q[1]) begin
            pulse_d = 1'b0;
        end else if (rise_s) begin
            pulse_d = 1'b1;
        end else if (fall_s) begin
            pulse_d = 1'b0;
        end else begin
            pulse_d = pulse_q;
        end

        rx_shift_d = rx_shift_q;
        rx_bits_d  = rx_bits_q;
        if (!ctrl_q[1]) begin
            rx_shift_d = {DATA_W{1'b0}};
            rx_bits_d  = {BCW{1'b0}};
        end else if (bit_valid_s) begin
            if (rx_push_req_s) begin
                rx_shift_d = {DATA_W{1'b0}};
                rx_bits_d  = {BCW{1'b0}};
            end else begin
                rx_shift_d = rx_shift_next_s;
                rx_bits_d  = rx_bits_q + BCW'(1);
            end
        end else if (gap_s && (rx_bits_q != {BCW{1'b0}})) begin
            // Line idle too long mid-character: drop the partial and resync.
            rx_shift_d = {DATA_W{1'b0}};
            rx_bits_d  = {BCW{1'b0}};
        end else begin
            rx_shift_d = rx_shift_q;
            rx_bits_d  = rx_bits_q;
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    logic [15:0] status_s;
    logic        irq_q, irq_d;

    assign status_s = {9'b0, tx_ovf_q, tx_busy_s, rx_ovf_q, tx_empty_s,
                       tx_full_s, rx_full_s, ~rx_empty_s};
    assign irq_d    = (ctrl_q[2] & ~rx_empty_s) |
                      (ctrl_q[3] & tx_empty_s & ~tx_busy_s);

    // Combinational register read; unselected or unmapped reads return zero.
    always_comb begin
        mmio_rdata = 16'h0000;
        if (sel_s) begin
            case (off_s)
                4'd0:    mmio_rdata = status_s;
                4'd1:    mmio_rdata = rx_empty_s ? 16'h0000 : 16'(rx_head_s);
                4'd3:    mmio_rdata = {12'h000, ctrl_q};
                4'd4:    mmio_rdata = 16'(rx_cnt_q);
                4'd5:    mmio_rdata = 16'(tx_cnt_q);
                default: mmio_rdata = 16'h0000;
            endcase
        end else begin
            mmio_rdata = 16'h0000;
        end
    end

    // All state registers; reset abandons any character in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 4'b0011;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            tx_wr_q     <= {AW{1'b0}};
            tx_rd_q     <= {AW{1'b0}};
            tx_cnt_q    <= {CW{1'b0}};
            rx_wr_q     <= {AW{1'b0}};
            rx_rd_q     <= {AW{1'b0}};
            rx_cnt_q    <= {CW{1'b0}};
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= {DATA_W{1'b0}};
            tx_bit_q    <= {BCW{1'b0}};
            tx_slot_q   <= {SCW{1'b0}};
            serial_tx_q <= 1'b0;
            rx_s1_q     <= 1'b0;
            rx_s2_q     <= 1'b0;
            rx_s3_q     <= 1'b0;
            hi_cnt_q    <= {HCW{1'b0}};
            lo_cnt_q    <= {LCW{1'b0}};
            pulse_q     <= 1'b0;
            rx_shift_q  <= {DATA_W{1'b0}};
            rx_bits_q   <= {BCW{1'b0}};
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_slot_q   <= tx_slot_d;
            serial_tx_q <= serial_tx_d;
            rx_s1_q     <= serial_rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            hi_cnt_q    <= hi_cnt_d;
            lo_cnt_q    <= lo_cnt_d;
            pulse_q     <= pulse_d;
            rx_shift_q  <= rx_shift_d;
            rx_bits_q   <= rx_bits_d;
            irq_q       <= irq_d;
        end
    end

    assign serial_tx = serial_tx_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_serial_mmio.sv
// Directed testbench for serial_mmio (DATA_W=8, FIFO_DEPTH=4, BIT_PERIOD=16).
module tb_serial_mmio;

    localparam logic [15:0] A_STATUS = 16'h8100;
    localparam logic [15:0] A_RXDATA = 16'h8101;
    localparam logic [15:0] A_TXDATA = 16'h8102;
    localparam logic [15:0] A_CTRL   = 16'h8103;
    localparam logic [15:0] A_RXCNT  = 16'h8104;
    localparam logic [15:0] A_TXCNT  = 16'h8105;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mmio_addr;
    logic [15:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [15:0] mmio_rdata;
    logic        serial_tx;
    logic        serial_rx;
    logic        irq;
    logic        loop_en;
    logic        rx_drive;

    int checks = 0;
    int errors = 0;

    assign serial_rx = loop_en ? serial_tx : rx_drive;

    serial_mmio dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_we    (mmio_we),
        .mmio_re    (mmio_re),
        .mmio_rdata (mmio_rdata),
        .serial_tx  (serial_tx),
        .serial_rx  (serial_rx),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic mmio_write(input logic [15:0] a, input logic [15:0] d);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_we    = 1'b1;
        @(posedge clk);
        #1;
        mmio_we = 1'b0;
    endtask

    task automatic mmio_read(input logic [15:0] a, output logic [15:0] d);
        @(posedge clk);
        #1;
        mmio_addr = a;
        mmio_re   = 1'b0;
        #1;
        d = mmio_rdata;
    endtask

    task automatic mmio_pop(output logic [15:0] d);
        @(posedge clk);
        #1;
        mmio_addr = A_RXDATA;
        mmio_re   = 1'b1;
        #1;
        d = mmio_rdata;
        @(posedge clk);
        #1;
        mmio_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One pulse-width-coded bit slot driven onto the receive line.
    task automatic drive_bit(input logic b);
        for (int j = 0; j < 16; j++) begin
            rx_drive = (j < 4) || ((j < 12) && b);
            @(posedge clk);
            #1;
        end
        rx_drive = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx got %b exp 0", serial_tx);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b exp 0", irq);
        end
        rst_n = 1'b1;
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL reset_status got %h exp 0008", d);
        end
        mmio_read(A_CTRL, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0003", d);
        end
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rxcnt got %h exp 0000", d);
        end
        mmio_read(A_TXCNT, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL reset_txcnt got %h exp 0000", d);
        end
    endtask

    task automatic test_select();
        logic [15:0] d;
        mmio_read(16'h0100, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL sel_bit15 got %h exp 0000", d);
        end
        mmio_read(16'h8200, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL sel_page got %h exp 0000", d);
        end
        mmio_read(16'h81F0, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL sel_alias got %h exp 0008", d);
        end
        mmio_read(16'h8106, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL sel_unmapped got %h exp 0000", d);
        end
        mmio_write(16'h8202, 16'h0077);
        mmio_write(16'h0102, 16'h0077);
        mmio_read(A_TXCNT, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL sel_write_ignored got %h exp 0000", d);
        end
        idle(4);
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL sel_tx_quiet got %b exp 0", serial_tx);
        end
    endtask

    task automatic test_tx_waveform();
        logic [15:0] d;
        int hi [8];
        int exp_w [8] = '{12, 4, 12, 4, 4, 12, 4, 12};
        for (int i = 0; i < 8; i++) hi[i] = 0;
        loop_en  = 1'b0;
        rx_drive = 1'b0;
        mmio_write(A_TXDATA, 16'h00A5);
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL tx_e0 got %b exp 0", serial_tx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL tx_e1 got %b exp 0", serial_tx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (serial_tx !== 1'b1) begin
            errors++;
            $display("FAIL tx_e2 got %b exp 1", serial_tx);
        end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (serial_tx === 1'b1) hi[k / 16]++;
        end
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (hi[s] !== exp_w[s]) begin
                errors++;
                $display("FAIL tx_width slot %0d got %0d exp %0d", s, hi[s], exp_w[s]);
            end
        end
        idle(4);
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL tx_done_status got %h exp 0008", d);
        end
    endtask

    task automatic test_loopback();
        logic [15:0] d;
        logic [15:0] pair = 16'h3C81;
        int hi [16];
        int starts = 0;
        for (int i = 0; i < 16; i++) hi[i] = 0;
        loop_en = 1'b1;
        mmio_write(A_TXDATA, 16'h003C);
        mmio_write(A_TXDATA, 16'h0081);
        @(posedge clk);
        #1;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (serial_tx === 1'b1) hi[k / 16]++;
            if ((k % 16 == 0) && (serial_tx === 1'b1)) starts++;
        end
        for (int s = 0; s < 16; s++) begin
            checks++;
            if (hi[s] !== (pair[15-s] ? 12 : 4)) begin
                errors++;
                $display("FAIL loop_width slot %0d got %0d exp %0d", s, hi[s], pair[15-s] ? 12 : 4);
            end
        end
        checks++;
        if (starts !== 16) begin
            errors++;
            $display("FAIL loop_no_gap got %0d exp 16", starts);
        end
        idle(10);
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("FAIL loop_rxcnt got %h exp 0002", d);
        end
        mmio_pop(d);
        checks++;
        if (d !== 16'h003C) begin
            errors++;
            $display("FAIL loop_rx0 got %h exp 003c", d);
        end
        mmio_pop(d);
        checks++;
        if (d !== 16'h0081) begin
            errors++;
            $display("FAIL loop_rx1 got %h exp 0081", d);
        end
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL loop_status got %h exp 0008", d);
        end
    endtask

    task automatic test_rx_overflow();
        logic [15:0] d;
        logic [15:0] exp_c [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        loop_en = 1'b1;
        mmio_write(A_TXDATA, 16'h0011);
        mmio_write(A_TXDATA, 16'h0022);
        mmio_write(A_TXDATA, 16'h0033);
        mmio_write(A_TXDATA, 16'h0044);
        mmio_write(A_TXDATA, 16'h0055);
        idle(5 * 128 + 20);
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL ovf_rxcnt got %h exp 0004", d);
        end
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h001B) begin
            errors++;
            $display("FAIL ovf_status got %h exp 001b", d);
        end
        mmio_write(A_CTRL, 16'h0013);
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h000B) begin
            errors++;
            $display("FAIL ovf_clear got %h exp 000b", d);
        end
        for (int i = 0; i < 4; i++) begin
            mmio_pop(d);
            checks++;
            if (d !== exp_c[i]) begin
                errors++;
                $display("FAIL ovf_rx%0d got %h exp %h", i, d, exp_c[i]);
            end
        end
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL ovf_drained got %h exp 0008", d);
        end
    endtask

    task automatic test_tx_overflow();
        logic [15:0] d;
        logic [15:0] exp_c [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
        loop_en = 1'b1;
        mmio_write(A_CTRL, 16'h0000);
        for (int i = 1; i <= 5; i++) mmio_write(A_TXDATA, 16'h00A0 + 16'(i));
        mmio_read(A_TXCNT, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL txovf_cnt got %h exp 0004", d);
        end
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0044) begin
            errors++;
            $display("FAIL txovf_status got %h exp 0044", d);
        end
        mmio_write(A_CTRL, 16'h0003);
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0060) begin
            errors++;
            $display("FAIL txovf_busy got %h exp 0060", d);
        end
        idle(4 * 128 + 20);
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++;
            $display("FAIL txovf_rxcnt got %h exp 0004", d);
        end
        for (int i = 0; i < 4; i++) begin
            mmio_pop(d);
            checks++;
            if (d !== exp_c[i]) begin
                errors++;
                $display("FAIL txovf_rx%0d got %h exp %h", i, d, exp_c[i]);
            end
        end
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0048) begin
            errors++;
            $display("FAIL txovf_after got %h exp 0048", d);
        end
        mmio_write(A_CTRL, 16'h0013);
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL txovf_clear got %h exp 0008", d);
        end
    endtask

    task automatic test_irq();
        logic [15:0] d;
        loop_en = 1'b1;
        mmio_write(A_CTRL, 16'h000B);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_lag got %b exp 0", irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_txe got %b exp 1", irq);
        end
        mmio_write(A_CTRL, 16'h0007);
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_rx_empty got %b exp 0", irq);
        end
        mmio_write(A_TXDATA, 16'h005A);
        idle(150);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rx got %b exp 1", irq);
        end
        mmio_pop(d);
        checks++;
        if (d !== 16'h005A) begin
            errors++;
            $display("FAIL irq_rxdata got %h exp 005a", d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_cleared got %b exp 0", irq);
        end
        mmio_write(A_CTRL, 16'h0003);
    endtask

    task automatic test_gap_resync();
        logic [15:0] d;
        logic [7:0]  c = 8'h55;
        loop_en  = 1'b0;
        rx_drive = 1'b0;
        idle(4);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(40);
        for (int i = 7; i >= 0; i--) drive_bit(c[i]);
        idle(10);
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL gap_rxcnt got %h exp 0001", d);
        end
        mmio_pop(d);
        checks++;
        if (d !== 16'h0055) begin
            errors++;
            $display("FAIL gap_rxdata got %h exp 0055", d);
        end
    endtask

    task automatic test_glitch();
        logic [15:0] d;
        logic [7:0]  c = 8'hC3;
        loop_en  = 1'b0;
        rx_drive = 1'b0;
        for (int i = 7; i >= 4; i--) drive_bit(c[i]);
        rx_drive = 1'b1;
        @(posedge clk);
        #1;
        rx_drive = 1'b0;
        idle(3);
        for (int i = 3; i >= 0; i--) drive_bit(c[i]);
        idle(10);
        mmio_read(A_RXCNT, d);
        checks++;
        if (d !== 16'h0001) begin
            errors++;
            $display("FAIL glitch_rxcnt got %h exp 0001", d);
        end
        mmio_pop(d);
        checks++;
        if (d !== 16'h00C3) begin
            errors++;
            $display("FAIL glitch_rxdata got %h exp 00c3", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        loop_en  = 1'b0;
        rx_drive = 1'b0;
        mmio_write(A_TXDATA, 16'h00FF);
        repeat (52) @(posedge clk);
        #1;
        checks++;
        if (serial_tx !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_high got %b exp 1", serial_tx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 0", serial_tx);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mmio_read(A_STATUS, d);
        checks++;
        if (d !== 16'h0008) begin
            errors++;
            $display("FAIL rstmid_status got %h exp 0008", d);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_irq got %b exp 0", irq);
        end
        mmio_read(A_TXCNT, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_txcnt got %h exp 0000", d);
        end
        idle(20);
        checks++;
        if (serial_tx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abandon got %b exp 0", serial_tx);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mmio_addr  = 16'h0000;
        mmio_wdata = 16'h0000;
        mmio_we    = 1'b0;
        mmio_re    = 1'b0;
        loop_en    = 1'b0;
        rx_drive   = 1'b0;
        test_reset();
        test_select();
        test_tx_waveform();
        test_loopback();
        test_rx_overflow();
        test_tx_overflow();
        test_irq();
        test_gap_resync();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
